// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared types and default geometry for the data cache
package cache_pkg;

  localparam int DEFAULT_NUM_SETS   = 16;
  localparam int DEFAULT_LINE_WORDS = 4;

  // Address split at the default geometry: byte bits, word offset, index, tag
  localparam int OFFSET_W = $clog2(DEFAULT_LINE_WORDS);
  localparam int INDEX_W  = $clog2(DEFAULT_NUM_SETS);
  localparam int TAG_W    = 32 - INDEX_W - OFFSET_W - 2;

  typedef enum logic [2:0] {
    IDLE,
    TAG_CHECK,
    WRITE_BACK,
    ALLOCATE,
    WAIT_FILL
  } state_t;

endpackage

// File: rtl/cache_line_array.sv
// rtl/cache_line_array.sv - tag/valid/dirty/data storage for a direct-mapped cache
module cache_line_array
  import cache_pkg::*;
#(
  parameter int NUM_SETS   = DEFAULT_NUM_SETS,
  parameter int LINE_WORDS = DEFAULT_LINE_WORDS,
  parameter int OFF_W      = OFFSET_W,
  parameter int IDX_W      = INDEX_W,
  parameter int TW         = TAG_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [IDX_W-1:0]        index,
  output logic                    rd_valid,
  output logic                    rd_dirty,
  output logic [TW-1:0]           rd_tag,
  output logic [32*LINE_WORDS-1:0] rd_line,
  input  logic                    wr_en,
  input  logic [OFF_W-1:0]        wr_offset,
  input  logic [31:0]             wr_data,
  input  logic                    fill_en,
  input  logic [TW-1:0]           fill_tag,
  input  logic [32*LINE_WORDS-1:0] fill_line
);

  logic [TW-1:0]             tag_mem  [NUM_SETS];
  logic [32*LINE_WORDS-1:0]  data_mem [NUM_SETS];
  logic [NUM_SETS-1:0]       valid_bits;
  logic [NUM_SETS-1:0]       dirty_bits;

  assign rd_valid = valid_bits[index];
  assign rd_dirty = dirty_bits[index];
  assign rd_tag   = tag_mem[index];
  assign rd_line  = data_mem[index];

  // Line state: a fill makes the line valid and clean, a word store makes it dirty
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_bits <= '0;
      dirty_bits <= '0;
    end else if (fill_en) begin
      valid_bits[index] <= 1'b1;
      dirty_bits[index] <= 1'b0;
    end else if (wr_en) begin
      dirty_bits[index] <= 1'b1;
    end
  end

  // Tag and data payload; contents are meaningless until the valid bit is set
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_mem[index]  <= fill_tag;
      data_mem[index] <= fill_line;
    end else if (wr_en) begin
      data_mem[index][{wr_offset, 5'b00000} +: 32] <= wr_data;
    end
  end

endmodule

// File: rtl/data_cache.sv
// rtl/data_cache.sv - direct-mapped write-back write-allocate data cache
module data_cache
  import cache_pkg::*;
#(
  parameter int NUM_SETS   = DEFAULT_NUM_SETS,
  parameter int LINE_WORDS = DEFAULT_LINE_WORDS
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     is_input_valid,
  input  logic [31:0]              addr,
  input  logic                     mem_read,
  input  logic                     mem_write,
  input  logic [31:0]              din,
  output logic                     is_ready,
  output logic                     is_output_valid,
  output logic [31:0]              dout,
  output logic                     is_hit,
  output logic [31:0]              hit_count,
  output logic [31:0]              miss_count,
  output logic                     mem_req_valid,
  output logic                     mem_req_we,
  output logic [31:0]              mem_req_addr,
  output logic [32*LINE_WORDS-1:0] mem_req_data,
  input  logic                     mem_req_ready,
  input  logic                     mem_resp_valid,
  input  logic [32*LINE_WORDS-1:0] mem_resp_data
);

  localparam int OW = $clog2(LINE_WORDS);
  localparam int IW = $clog2(NUM_SETS);
  localparam int TW = 32 - IW - OW - 2;
  localparam int LB = 32 * LINE_WORDS;

  state_t        state;
  logic [31:2]   req_addr;
  logic [31:0]   req_din;
  logic          req_write;
  logic          missed;

  logic [OW-1:0] req_off;
  logic [IW-1:0] req_idx;
  logic [TW-1:0] req_tag;

  logic          rd_valid;
  logic          rd_dirty;
  logic [TW-1:0] rd_tag;
  logic [LB-1:0] rd_line;
  logic [31:0]   rd_word;
  logic          hit;
  logic          accept;
  logic          wr_en;
  logic          fill_en;

  // Byte lane bits never select anything: the cache is word-granular
  wire unused_addr_lsbs = ^addr[1:0];

  assign req_off = req_addr[OW+1:2];
  assign req_idx = req_addr[OW+2 +: IW];
  assign req_tag = req_addr[31 -: TW];

  assign rd_word = rd_line[{req_off, 5'b00000} +: 32];
  assign hit     = rd_valid && (rd_tag == req_tag);
  assign accept  = is_input_valid && is_ready && (mem_read ^ mem_write);
  assign wr_en   = (state == TAG_CHECK) && hit && req_write;
  assign fill_en = (state == WAIT_FILL) && mem_resp_valid;

  cache_line_array #(
    .NUM_SETS   (NUM_SETS),
    .LINE_WORDS (LINE_WORDS),
    .OFF_W      (OW),
    .IDX_W      (IW),
    .TW         (TW)
  ) u_lines (
    .clk       (clk),
    .reset     (reset),
    .index     (req_idx),
    .rd_valid  (rd_valid),
    .rd_dirty  (rd_dirty),
    .rd_tag    (rd_tag),
    .rd_line   (rd_line),
    .wr_en     (wr_en),
    .wr_offset (req_off),
    .wr_data   (req_din),
    .fill_en   (fill_en),
    .fill_tag  (req_tag),
    .fill_line (mem_resp_data)
  );

  // Request sequencing: lookup, optional victim write-back, refill, then re-lookup
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      req_addr        <= '0;
      req_din         <= '0;
      req_write       <= 1'b0;
      missed          <= 1'b0;
      is_ready        <= 1'b1;
      is_output_valid <= 1'b0;
      dout            <= '0;
      is_hit          <= 1'b0;
      hit_count       <= '0;
      miss_count      <= '0;
      mem_req_valid   <= 1'b0;
      mem_req_we      <= 1'b0;
      mem_req_addr    <= '0;
      mem_req_data    <= '0;
    end else begin
      is_output_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            req_addr  <= addr[31:2];
            req_din   <= din;
            req_write <= mem_write;
            is_ready  <= 1'b0;
            state     <= TAG_CHECK;
          end
        end
        TAG_CHECK: begin
          if (hit) begin
            if (!req_write) begin
              dout <= rd_word;
            end
            is_output_valid <= 1'b1;
            is_hit          <= !missed;
            if (missed) begin
              miss_count <= miss_count + 32'd1;
            end else begin
              hit_count <= hit_count + 32'd1;
            end
            missed   <= 1'b0;
            is_ready <= 1'b1;
            state    <= IDLE;
          end else begin
            missed        <= 1'b1;
            mem_req_valid <= 1'b1;
            if (rd_valid && rd_dirty) begin
              mem_req_we   <= 1'b1;
              mem_req_addr <= {rd_tag, req_idx, {(OW+2){1'b0}}};
              mem_req_data <= rd_line;
              state        <= WRITE_BACK;
            end else begin
              mem_req_we   <= 1'b0;
              mem_req_addr <= {req_tag, req_idx, {(OW+2){1'b0}}};
              state        <= ALLOCATE;
            end
          end
        end
        WRITE_BACK: begin
          if (mem_req_ready) begin
            mem_req_we   <= 1'b0;
            mem_req_addr <= {req_tag, req_idx, {(OW+2){1'b0}}};
            state        <= ALLOCATE;
          end
        end
        ALLOCATE: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state         <= WAIT_FILL;
          end
        end
        WAIT_FILL: begin
          if (mem_resp_valid) begin
            state <= TAG_CHECK;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
